// File: rtl/pa_core_wbu.sv
// Write-back unit: merges execute results and in-order load responses onto the
// single register-file write port, buffering execute results and raising decode hazard stalls.
module pa_core_wbu #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int LD_OUTS    = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              exu_wb_vld_i,
    input  logic [REG_AW-1:0] exu_wb_addr_i,
    input  logic [DATA_W-1:0] exu_wb_data_i,
    output logic              exu_wb_rdy_o,
    input  logic              lsu_ld_issue_i,
    input  logic [REG_AW-1:0] lsu_ld_issue_addr_i,
    output logic              lsu_ld_issue_rdy_o,
    input  logic              lsu_ld_rsp_vld_i,
    input  logic [DATA_W-1:0] lsu_ld_rsp_data_i,
    input  logic [REG_AW-1:0] dec_rs1_i,
    input  logic [REG_AW-1:0] dec_rs2_i,
    input  logic [REG_AW-1:0] dec_rd_i,
    output logic              stall_o,
    output logic [REG_AW-1:0] reg_waddr_o,
    output logic              reg_waddr_vld_o,
    output logic [DATA_W-1:0] reg_wdata_o
);

    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int LPW = (LD_OUTS > 1) ? $clog2(LD_OUTS) : 1;
    localparam int LCW = $clog2(LD_OUTS + 1);

    logic [REG_AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [FPW-1:0]    fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [FCW-1:0]    fifo_cnt_q, fifo_cnt_d;

    logic [REG_AW-1:0] lq_addr_q [LD_OUTS];
    logic [LPW-1:0]    lq_rd_q, lq_rd_d, lq_wr_q, lq_wr_d;
    logic [LCW-1:0]    lq_cnt_q, lq_cnt_d;

    logic [REG_AW-1:0] reg_waddr_q, reg_waddr_d;
    logic              reg_vld_q, reg_vld_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

    logic fifo_empty_s, fifo_full_s, lq_empty_s, lq_full_s;
    logic rsp_s, iss_s, exu_acc_s, exu_keep_s;
    logic fifo_pop_s, fifo_push_s, direct_s;
    logic stall_s;
    logic [REG_AW-1:0] lq_head_s;

    // True when a tracked destination collides with any decode operand; x0 never hazards.
    function automatic logic hazard_f(input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] rs1,
                                      input logic [REG_AW-1:0] rs2,
                                      input logic [REG_AW-1:0] rd);
        return (a != {REG_AW{1'b0}}) && ((a == rs1) || (a == rs2) || (a == rd));
    endfunction

    assign fifo_empty_s = (fifo_cnt_q == {FCW{1'b0}});
    assign fifo_full_s  = (fifo_cnt_q == FCW'(FIFO_DEPTH));
    assign lq_empty_s   = (lq_cnt_q == {LCW{1'b0}});
    assign lq_full_s    = (lq_cnt_q == LCW'(LD_OUTS));
    assign lq_head_s    = lq_addr_q[lq_rd_q];

    // A response with nothing outstanding is ignored rather than writing garbage.
    assign rsp_s       = lsu_ld_rsp_vld_i && !lq_empty_s;
    assign iss_s       = lsu_ld_issue_i && !lq_full_s;
    assign exu_acc_s   = exu_wb_vld_i && !fifo_full_s;
    assign exu_keep_s  = exu_acc_s && (exu_wb_addr_i != {REG_AW{1'b0}});
    assign fifo_pop_s  = !rsp_s && !fifo_empty_s;
    assign direct_s    = !rsp_s && fifo_empty_s && exu_keep_s;
    assign fifo_push_s = exu_keep_s && !direct_s;

    // Write-port arbitration: load response, then FIFO head, then direct execute result.
    always_comb begin
        reg_vld_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        if (rsp_s) begin
            reg_vld_d   = (lq_head_s != {REG_AW{1'b0}});
            reg_waddr_d = lq_head_s;
            reg_wdata_d = lsu_ld_rsp_data_i;
        end else if (!fifo_empty_s) begin
            reg_vld_d   = 1'b1;
            reg_waddr_d = fifo_addr_q[fifo_rd_q];
            reg_wdata_d = fifo_data_q[fifo_rd_q];
        end else if (exu_keep_s) begin
            reg_vld_d   = 1'b1;
            reg_waddr_d = exu_wb_addr_i;
            reg_wdata_d = exu_wb_data_i;
        end else begin
            reg_vld_d   = 1'b0;
        end
    end

    // Pointer and occupancy next-state for both queues.
    always_comb begin
        fifo_rd_d = fifo_pop_s ?
                    ((fifo_rd_q == FPW'(FIFO_DEPTH - 1)) ? {FPW{1'b0}} : fifo_rd_q + FPW'(1)) : fifo_rd_q;
        fifo_wr_d = fifo_push_s ?
                    ((fifo_wr_q == FPW'(FIFO_DEPTH - 1)) ? {FPW{1'b0}} : fifo_wr_q + FPW'(1)) : fifo_wr_q;
        lq_rd_d   = rsp_s ?
                    ((lq_rd_q == LPW'(LD_OUTS - 1)) ? {LPW{1'b0}} : lq_rd_q + LPW'(1)) : lq_rd_q;
        lq_wr_d   = iss_s ?
                    ((lq_wr_q == LPW'(LD_OUTS - 1)) ? {LPW{1'b0}} : lq_wr_q + LPW'(1)) : lq_wr_q;
        case ({fifo_push_s, fifo_pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({iss_s, rsp_s})
            2'b10:   lq_cnt_d = lq_cnt_q + LCW'(1);
            2'b01:   lq_cnt_d = lq_cnt_q - LCW'(1);
            default: lq_cnt_d = lq_cnt_q;
        endcase
    end

    // Hazard detection over live queue entries and the in-flight register write.
    always_comb begin
        stall_s = 1'b0;
        for (int i = 0; i < LD_OUTS; i++) begin
            stall_s = stall_s |
                      ((32'(LPW'(LPW'(i) - lq_rd_q)) < 32'(lq_cnt_q)) &&
                       hazard_f(lq_addr_q[i], dec_rs1_i, dec_rs2_i, dec_rd_i));
        end
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            stall_s = stall_s |
                      ((32'(FPW'(FPW'(j) - fifo_rd_q)) < 32'(fifo_cnt_q)) &&
                       hazard_f(fifo_addr_q[j], dec_rs1_i, dec_rs2_i, dec_rd_i));
        end
        stall_s = stall_s | (reg_vld_q && hazard_f(reg_waddr_q, dec_rs1_i, dec_rs2_i, dec_rd_i));
    end

    // State registers; reset discards buffered writes and outstanding-load tracking.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fifo_rd_q   <= {FPW{1'b0}};
            fifo_wr_q   <= {FPW{1'b0}};
            fifo_cnt_q  <= {FCW{1'b0}};
            lq_rd_q     <= {LPW{1'b0}};
            lq_wr_q     <= {LPW{1'b0}};
            lq_cnt_q    <= {LCW{1'b0}};
            reg_waddr_q <= {REG_AW{1'b0}};
            reg_vld_q   <= 1'b0;
            reg_wdata_q <= {DATA_W{1'b0}};
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_addr_q[k] <= {REG_AW{1'b0}};
                fifo_data_q[k] <= {DATA_W{1'b0}};
            end
            for (int m = 0; m < LD_OUTS; m++) begin
                lq_addr_q[m] <= {REG_AW{1'b0}};
            end
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            lq_rd_q     <= lq_rd_d;
            lq_wr_q     <= lq_wr_d;
            lq_cnt_q    <= lq_cnt_d;
            reg_waddr_q <= reg_waddr_d;
            reg_vld_q   <= reg_vld_d;
            reg_wdata_q <= reg_wdata_d;
            if (fifo_push_s) begin
                fifo_addr_q[fifo_wr_q] <= exu_wb_addr_i;
                fifo_data_q[fifo_wr_q] <= exu_wb_data_i;
            end
            if (iss_s) begin
                lq_addr_q[lq_wr_q] <= lsu_ld_issue_addr_i;
            end
        end
    end

    assign exu_wb_rdy_o       = !fifo_full_s;
    assign lsu_ld_issue_rdy_o = !lq_full_s;
    assign stall_o            = stall_s;
    assign reg_waddr_o        = reg_waddr_q;
    assign reg_waddr_vld_o    = reg_vld_q;
    assign reg_wdata_o        = reg_wdata_q;

endmodule

// File: doc/pa_core_wbu.md
Name: pa_core_wbu

Overview:
Write-back unit in front of the core register-file/CSR retire block. It merges single-cycle execute results and in-order load responses onto the single integer register write port (reg_waddr/reg_waddr_vld/reg_wdata), and buffers execute results in a small FIFO when a load response takes the port. It tracks outstanding load destinations and not-yet-written results, and raises a decode stall on RAW/WAW hazards against them.

Parameters:
DATA_W, 32, data width; equals DATA_BUS_WIDTH
REG_AW, 5, register address width; equals REG_BUS_WIDTH
FIFO_DEPTH, 2, execute-result buffer entries; power of two, at least 2
LD_OUTS, 2, maximum outstanding loads; power of two, at least 1

Ports:
clk_i  input  1  core clock; all state updates on the rising edge
rst_n_i  input  1  asynchronous active-low reset
exu_wb_vld_i  input  1  execute result valid
exu_wb_addr_i  input  REG_AW  execute destination register
exu_wb_data_i  input  DATA_W  execute result
exu_wb_rdy_o  output  1  execute result accepted; equals FIFO not full
lsu_ld_issue_i  input  1  load issued this cycle
lsu_ld_issue_addr_i  input  REG_AW  load destination register
lsu_ld_issue_rdy_o  output  1  outstanding-load queue not full
lsu_ld_rsp_vld_i  input  1  load response valid; responses return in issue order
lsu_ld_rsp_data_i  input  DATA_W  load response data
dec_rs1_i  input  REG_AW  decode source register 1
dec_rs2_i  input  REG_AW  decode source register 2
dec_rd_i  input  REG_AW  decode destination register
stall_o  output  1  decode hazard stall; combinational
reg_waddr_o  output  REG_AW  register-file write address; registered
reg_waddr_vld_o  output  1  register-file write enable; registered
reg_wdata_o  output  DATA_W  register-file write data; registered

Behaviour:
- Reset (asynchronous, active-low): FIFO empty; load queue empty; reg_waddr_o = 0, reg_waddr_vld_o = 0, reg_wdata_o = 0. After reset: exu_wb_rdy_o = 1, lsu_ld_issue_rdy_o = 1, stall_o = 0. Reset mid-operation discards all buffered writes and outstanding-load tracking.
- Write port: reg_* is a one-stage output register. Data is written to the register file on the edge after reg_waddr_vld_o is seen high. Latency from an accepted input to reg_waddr_vld_o = 1 cycle when it wins arbitration.
- Arbitration each cycle, in fixed priority:
  1. Load response.
  2. FIFO head.
  3. Direct execute result (bypasses the FIFO only when the FIFO is empty).
- An execute result that loses arbitration, or arrives while the FIFO is non-empty, is pushed into the FIFO. Push and pop may happen in the same cycle; the count is then unchanged.
- An execute result is accepted only when exu_wb_vld_i && exu_wb_rdy_o. A result presented when the FIFO is full is not accepted and must be held by the producer.
- Destination x0: an execute result to x0 is accepted and dropped (no FIFO entry, no write). A load to x0 still occupies a queue slot; its response pops the queue with reg_waddr_vld_o = 0.
- Load queue: in-order FIFO of destination addresses, depth LD_OUTS.
  - Push on lsu_ld_issue_i && lsu_ld_issue_rdy_o; an issue while full is ignored.
  - Pop on lsu_ld_rsp_vld_i; the popped address is the write address.
  - Simultaneous issue and response: pop and push in the same cycle.
  - A response while the queue is empty is ignored (no write); the bench flags it as a protocol error.
- Write ordering: no two pending writes share a non-x0 rd, because stall_o is raised on WAW. Arbitration order therefore never corrupts architectural state.
- stall_o = 1 when any of dec_rs1_i, dec_rs2_i or dec_rd_i is non-zero and equals:
  - any valid load-queue address,
  - any valid FIFO entry address, or
  - reg_waddr_o while reg_waddr_vld_o = 1 (the register-file read has no bypass).
- Address and pointer widths: FIFO and queue pointers wrap modulo the depth; full and empty are derived from a count.

Test Plan:
1. Reset with ports idle -> all outputs 0 except exu_wb_rdy_o = 1 and lsu_ld_issue_rdy_o = 1; an exu write (x5, 0x1234) one cycle later -> next cycle reg_waddr_o = 5, reg_waddr_vld_o = 1, reg_wdata_o = 0x1234.
2. Issue a load to x7, then in the same cycle present a load response (0xAAAA) and an exu write (x3, 0x55) -> cycle +1 writes x7 = 0xAAAA, cycle +2 writes x3 = 0x55; FIFO is empty afterwards.
3. Two back-to-back load responses while the exu presents 3 results -> FIFO fills; exu_wb_rdy_o = 0 on the third result; the third result is written after the two buffered ones, strictly in order.
4. Issue 2 loads (x8, x9) -> lsu_ld_issue_rdy_o = 0 and a third issue is ignored; dec_rs1_i = 9 -> stall_o = 1; after both responses stall_o = 0.
5. Load to x0 and exu write to x0 -> no reg_waddr_vld_o pulse; dec_rs1_i = 0 never stalls; the queue pops on the response.
6. Assert rst_n_i low with the FIFO and queue half-full -> immediate clear; no writes after release.
